mem_bus_arbiter: RTL and testbench

//  Shares the single SDRAM burst port between the instruction-cache and data-cache controllers.
//  - Arbitrates miss/writeback requests (MStrobe-style pulses) round-robin.
//  - Holds the winner's grant for a whole burst, issues one command to the SDRAM controller
//    and steers the RxD/TxD beat strobes back to the winner only.
//  - Sits between the ICache/DCache FSMs and the SDRAM controller front end.

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter_rr_arb2.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the I/D cache SDRAM port arbiter: FSM encodings, requester IDs, defaults.
package mem_bus_arbiter_pkg;

  localparam int AW_DEF        = 32;
  localparam int BURST_LEN_DEF = 4;
  localparam int TIMEOUT_DEF   = 255;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_GRANT = 3'd1,
    ARB_CMD   = 3'd2,
    ARB_XFER  = 3'd3,
    ARB_DONE  = 3'd4,
    ARB_ABORT = 3'd5
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and SDRAM-side signals of the arbiter; master is the arbiter's view, slave the surroundings.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          i_req;
  logic          i_rw;
  logic [AW-1:0] i_addr;
  logic          i_grant;
  logic          i_rxd;
  logic          i_txd;

  logic          d_req;
  logic          d_rw;
  logic [AW-1:0] d_addr;
  logic          d_grant;
  logic          d_rxd;
  logic          d_txd;

  logic          sdr_req;
  logic          sdr_rw;
  logic [AW-1:0] sdr_addr;
  logic          sdr_cmd_ack;
  logic          sdr_rxd;
  logic          sdr_txd;
  logic          bus_err;

  modport master (
    input  i_req, i_rw, i_addr, d_req, d_rw, d_addr,
    input  sdr_cmd_ack, sdr_rxd, sdr_txd,
    output i_grant, i_rxd, i_txd, d_grant, d_rxd, d_txd,
    output sdr_req, sdr_rw, sdr_addr, bus_err
  );

  modport slave (
    output i_req, i_rw, i_addr, d_req, d_rw, d_addr,
    output sdr_cmd_ack, sdr_rxd, sdr_txd,
    input  i_grant, i_rxd, i_txd, d_grant, d_rxd, d_txd,
    input  sdr_req, sdr_rw, sdr_addr, bus_err
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not finish the last burst wins.
module mem_bus_arbiter_rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_want,
  input  logic    d_want,
  input  logic    upd,
  input  req_id_t upd_id,
  output logic    vld,
  output req_id_t win
);

  req_id_t last_winner;

  // Starting as D makes I the first tie winner after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= REQ_D;
    end else if (upd) begin
      last_winner <= upd_id;
    end
  end

  always_comb begin
    vld = i_want | d_want;
    win = REQ_I;
    if (i_want && d_want) begin
      win = (last_winner == REQ_I) ? REQ_D : REQ_I;
    end else if (d_want) begin
      win = REQ_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the SDRAM burst port between ICache and DCache: round-robin pick, one command per burst,
// beat strobes steered to the burst owner only; grant rises two cycles after the request.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic Clk,
  input  logic Reset,
  mem_bus_arbiter_if.master bus
);

  localparam int            BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [7:0]    TMO_LAST  = 8'(TIMEOUT - 1);

  arb_state_t    state;
  req_id_t       owner;
  logic          pend_i;
  logic          pend_d;
  logic          i_rw_q;
  logic          d_rw_q;
  logic [AW-1:0] i_addr_q;
  logic [AW-1:0] d_addr_q;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic          sdr_req_q;
  logic          i_grant_q;
  logic          d_grant_q;
  logic          bus_err_q;
  logic [7:0]    tmo;
  logic [BW-1:0] beat;

  logic    pick_vld;
  req_id_t pick;
  logic    take_i;
  logic    take_d;
  logic    in_xfer;
  logic    rd_beat;
  logic    wr_beat;
  logic    beat_hit;

  mem_bus_arbiter_rr_arb2 u_rr (
    .clk    (Clk),
    .rst    (Reset),
    .i_want (pend_i | bus.i_req),
    .d_want (pend_d | bus.d_req),
    .upd    (state == ARB_DONE),
    .upd_id (owner),
    .vld    (pick_vld),
    .win    (pick)
  );

  assign take_i = (state == ARB_IDLE) && pick_vld && (pick == REQ_I);
  assign take_d = (state == ARB_IDLE) && pick_vld && (pick == REQ_D);

  // Only the strobe matching the command direction counts; everything else is dropped.
  assign in_xfer  = (state == ARB_XFER);
  assign rd_beat  = in_xfer && cmd_rw && bus.sdr_rxd;
  assign wr_beat  = in_xfer && !cmd_rw && bus.sdr_txd;
  assign beat_hit = rd_beat | wr_beat;

  assign bus.i_rxd    = rd_beat && (owner == REQ_I);
  assign bus.i_txd    = wr_beat && (owner == REQ_I);
  assign bus.d_rxd    = rd_beat && (owner == REQ_D);
  assign bus.d_txd    = wr_beat && (owner == REQ_D);
  assign bus.i_grant  = i_grant_q;
  assign bus.d_grant  = d_grant_q;
  assign bus.sdr_req  = sdr_req_q;
  assign bus.sdr_rw   = cmd_rw;
  assign bus.sdr_addr = cmd_addr;
  assign bus.bus_err  = bus_err_q;

  // A request is captured only when its requester has nothing pending already.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_i   <= 1'b0;
      pend_d   <= 1'b0;
      i_rw_q   <= 1'b0;
      d_rw_q   <= 1'b0;
      i_addr_q <= '0;
      d_addr_q <= '0;
    end else begin
      if (bus.i_req && !pend_i) begin
        i_rw_q   <= bus.i_rw;
        i_addr_q <= bus.i_addr;
      end
      if (bus.d_req && !pend_d) begin
        d_rw_q   <= bus.d_rw;
        d_addr_q <= bus.d_addr;
      end
      if (take_i) pend_i <= 1'b0;
      else if (bus.i_req) pend_i <= 1'b1;
      if (take_d) pend_d <= 1'b0;
      else if (bus.d_req) pend_d <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ARB_IDLE;
      owner     <= REQ_I;
      cmd_rw    <= 1'b0;
      cmd_addr  <= '0;
      sdr_req_q <= 1'b0;
      i_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      bus_err_q <= 1'b0;
      tmo       <= '0;
      beat      <= '0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            owner <= pick;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          cmd_rw    <= (owner == REQ_I) ? i_rw_q : d_rw_q;
          cmd_addr  <= (owner == REQ_I) ? i_addr_q : d_addr_q;
          i_grant_q <= (owner == REQ_I);
          d_grant_q <= (owner == REQ_D);
          sdr_req_q <= 1'b1;
          tmo       <= '0;
          state     <= ARB_CMD;
        end
        ARB_CMD: begin
          if (bus.sdr_cmd_ack) begin
            sdr_req_q <= 1'b0;
            beat      <= '0;
            state     <= ARB_XFER;
          end else if (tmo == TMO_LAST) begin
            sdr_req_q <= 1'b0;
            i_grant_q <= 1'b0;
            d_grant_q <= 1'b0;
            bus_err_q <= 1'b1;
            state     <= ARB_ABORT;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        ARB_XFER: begin
          if (beat_hit) begin
            if (beat == BEAT_LAST) state <= ARB_DONE;
            else beat <= beat + 1'b1;
          end
        end
        // Grant is held through DONE so the cache sees its last strobe fall while still owning the bus.
        ARB_DONE: begin
          i_grant_q <= 1'b0;
          d_grant_q <= 1'b0;
          state     <= ARB_IDLE;
        end
        ARB_ABORT: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of arbitration rounds plus corner-case sequences.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int BL = BURST_LEN_DEF;

  logic Clk;
  logic Reset;

  mem_bus_arbiter_if #(.AW(32)) bus ();

  mem_bus_arbiter #(.AW(32), .BURST_LEN(BL), .TIMEOUT(255)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  int m_ir = 0, m_it = 0, m_dr = 0, m_dt = 0;
  int m_gi = 0, m_gd = 0, m_both = 0, m_err = 0;

  always @(negedge Clk) begin
    if (bus.i_rxd) m_ir++;
    if (bus.i_txd) m_it++;
    if (bus.d_rxd) m_dr++;
    if (bus.d_txd) m_dt++;
    if (bus.i_grant) m_gi++;
    if (bus.d_grant) m_gd++;
    if (bus.i_grant && bus.d_grant) m_both++;
    if (bus.bus_err) m_err++;
  end

  typedef struct {
    bit          ireq;
    bit          irw;
    logic [31:0] iaddr;
    bit          dreq;
    bit          drw;
    logic [31:0] daddr;
    int          ack_dly;
    int          nb;
    req_id_t     w0;
    req_id_t     w1;
  } vec_t;

  typedef struct {
    bit          found;
    req_id_t     who;
    bit          one_gnt;
    logic [31:0] addr;
    logic        rw;
    int          wait_c;
    int          gnt_cyc;
    int          own_beats;
    int          bad;
  } res_t;

  vec_t vt[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {23'd0, bus.i_grant, bus.i_rxd, bus.i_txd, bus.d_grant, bus.d_rxd, bus.d_txd,
            bus.sdr_req, bus.sdr_rw, bus.sdr_addr, bus.bus_err};
  endfunction

  // Plays the SDRAM controller for one burst and measures what the arbiter did with it.
  task automatic serve(input int ack_dly, input logic rw, input bit glitch, output res_t r);
    int s_ir, s_it, s_dr, s_dt, s_g, tot;
    r.found = 1'b0; r.who = REQ_I; r.one_gnt = 1'b0; r.addr = '0; r.rw = 1'b0;
    r.wait_c = 0; r.gnt_cyc = 0; r.own_beats = 0; r.bad = 0;
    while (!bus.sdr_req && r.wait_c < 300) begin
      cyc();
      r.wait_c++;
    end
    if (!bus.sdr_req) return;
    r.found   = 1'b1;
    r.who     = bus.d_grant ? REQ_D : REQ_I;
    r.one_gnt = bus.i_grant ^ bus.d_grant;
    r.addr    = bus.sdr_addr;
    r.rw      = bus.sdr_rw;
    s_ir = m_ir; s_it = m_it; s_dr = m_dr; s_dt = m_dt; s_g = m_gi + m_gd;
    repeat (ack_dly) cyc();
    bus.sdr_cmd_ack = 1'b1;
    cyc();
    bus.sdr_cmd_ack = 1'b0;
    for (int b = 0; b < BL; b++) begin
      if (glitch && b == 2) begin
        if (rw) bus.sdr_txd = 1'b1;
        else bus.sdr_rxd = 1'b1;
        cyc();
        bus.sdr_rxd = 1'b0;
        bus.sdr_txd = 1'b0;
      end
      if (rw) bus.sdr_rxd = 1'b1;
      else bus.sdr_txd = 1'b1;
      cyc();
      bus.sdr_rxd = 1'b0;
      bus.sdr_txd = 1'b0;
    end
    cyc();
    r.gnt_cyc = m_gi + m_gd - s_g;
    tot = (m_ir - s_ir) + (m_it - s_it) + (m_dr - s_dr) + (m_dt - s_dt);
    if (r.who == REQ_I) r.own_beats = rw ? (m_ir - s_ir) : (m_it - s_it);
    else r.own_beats = rw ? (m_dr - s_dr) : (m_dt - s_dt);
    r.bad = tot - r.own_beats;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    res_t        r;
    req_id_t     ew;
    logic [31:0] ea;
    logic        erw;
    int          s0, s1, cnt, wt;

    vt[0] = '{ireq:1, irw:1, iaddr:32'h0000_0200, dreq:1, drw:0, daddr:32'h0000_0300,
              ack_dly:3, nb:2, w0:REQ_I, w1:REQ_D};
    vt[1] = '{ireq:1, irw:0, iaddr:32'h0000_1000, dreq:1, drw:1, daddr:32'h0000_2000,
              ack_dly:1, nb:2, w0:REQ_I, w1:REQ_D};
    vt[2] = '{ireq:1, irw:1, iaddr:32'h0000_0100, dreq:0, drw:0, daddr:32'h0000_0000,
              ack_dly:3, nb:1, w0:REQ_I, w1:REQ_I};
    vt[3] = '{ireq:1, irw:1, iaddr:32'h0000_5000, dreq:1, drw:1, daddr:32'h0000_6000,
              ack_dly:0, nb:2, w0:REQ_D, w1:REQ_I};
    vt[4] = '{ireq:0, irw:0, iaddr:32'h0000_0000, dreq:1, drw:0, daddr:32'hFFFF_FFF0,
              ack_dly:2, nb:1, w0:REQ_D, w1:REQ_D};
    vt[5] = '{ireq:1, irw:0, iaddr:32'hDEAD_BEE0, dreq:0, drw:0, daddr:32'h0000_0000,
              ack_dly:0, nb:1, w0:REQ_I, w1:REQ_I};

    bus.i_req = 0; bus.i_rw = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_rw = 0; bus.d_addr = '0;
    bus.sdr_cmd_ack = 0; bus.sdr_rxd = 0; bus.sdr_txd = 0;
    Reset = 1'b1;
    repeat (3) cyc();
    Reset = 1'b0;
    check("reset outputs", outs(), 64'd0);

    // Strobes while idle must go nowhere.
    s0 = m_ir + m_it + m_dr + m_dt;
    bus.sdr_rxd = 1; bus.sdr_txd = 1;
    repeat (2) cyc();
    bus.sdr_rxd = 0; bus.sdr_txd = 0;
    cyc();
    check("idle strobes dropped", m_ir + m_it + m_dr + m_dt - s0, 0);

    for (int v = 0; v < 6; v++) begin
      bus.i_req = vt[v].ireq; bus.i_rw = vt[v].irw; bus.i_addr = vt[v].iaddr;
      bus.d_req = vt[v].dreq; bus.d_rw = vt[v].drw; bus.d_addr = vt[v].daddr;
      cyc();
      bus.i_req = 0; bus.d_req = 0;
      for (int b = 0; b < vt[v].nb; b++) begin
        ew  = (b == 0) ? vt[v].w0 : vt[v].w1;
        ea  = (ew == REQ_I) ? vt[v].iaddr : vt[v].daddr;
        erw = (ew == REQ_I) ? vt[v].irw : vt[v].drw;
        serve(vt[v].ack_dly, erw, 1'b0, r);
        check($sformatf("v%0d.b%0d found", v, b), r.found, 1);
        check($sformatf("v%0d.b%0d winner", v, b), r.who, ew);
        check($sformatf("v%0d.b%0d one grant", v, b), r.one_gnt, 1);
        check($sformatf("v%0d.b%0d addr", v, b), r.addr, ea);
        check($sformatf("v%0d.b%0d rw", v, b), r.rw, erw);
        check($sformatf("v%0d.b%0d wait", v, b), r.wait_c, (b == 0) ? 1 : 2);
        check($sformatf("v%0d.b%0d grant cycles", v, b), r.gnt_cyc, vt[v].ack_dly + BL + 2);
        check($sformatf("v%0d.b%0d beats", v, b), r.own_beats, BL);
        check($sformatf("v%0d.b%0d misrouted", v, b), r.bad, 0);
      end
      check($sformatf("v%0d idle after", v), {bus.i_grant, bus.d_grant, bus.sdr_req}, 0);
    end

    // D write with a read strobe glitch in the middle of the transfer.
    bus.d_rw = 0; bus.d_addr = 32'h0000_0700; bus.d_req = 1;
    cyc();
    bus.d_req = 0;
    serve(3, 1'b0, 1'b1, r);
    check("glitch winner", r.who, REQ_D);
    check("glitch beats", r.own_beats, BL);
    check("glitch not routed", r.bad, 0);
    check("glitch grant cycles", r.gnt_cyc, 3 + BL + 3);

    // Grant latency, and a second D request absorbed while D is already pending.
    bus.i_rw = 0; bus.i_addr = 32'h0000_0B00; bus.i_req = 1;
    cyc();
    bus.i_req = 0;
    check("latency t+1 low", bus.i_grant, 0);
    bus.d_rw = 1; bus.d_addr = 32'h0000_00A0; bus.d_req = 1;
    cyc();
    check("latency t+2 high", bus.i_grant, 1);
    bus.d_addr = 32'h0000_00B0;
    cyc();
    bus.d_req = 0;
    serve(1, 1'b0, 1'b0, r);
    check("absorb I winner", r.who, REQ_I);
    check("absorb I addr", r.addr, 32'h0000_0B00);
    check("absorb I beats", r.own_beats, BL);
    serve(1, 1'b1, 1'b0, r);
    check("absorb D winner", r.who, REQ_D);
    check("absorb D first addr kept", r.addr, 32'h0000_00A0);
    check("absorb D back-to-back", r.wait_c, 2);
    check("absorb D beats", r.own_beats, BL);
    repeat (6) cyc();
    check("absorb no extra burst", {bus.sdr_req, bus.i_grant, bus.d_grant}, 0);

    // Command never acknowledged.
    bus.i_rw = 1; bus.i_addr = 32'h0000_0900; bus.i_req = 1;
    cyc();
    bus.i_req = 0;
    wt = 0;
    while (!bus.sdr_req && wt < 10) begin
      cyc();
      wt++;
    end
    s1 = m_err;
    cnt = 0;
    while (bus.sdr_req && cnt < 400) begin
      cyc();
      cnt++;
    end
    check("timeout cmd cycles", cnt, 255);
    check("timeout bus_err", bus.bus_err, 1);
    check("timeout grant drop", {bus.i_grant, bus.d_grant}, 0);
    cyc();
    check("timeout err one cycle", bus.bus_err, 0);
    repeat (5) cyc();
    check("timeout no retry", {bus.sdr_req, bus.i_grant, bus.d_grant}, 0);
    check("timeout err pulses", m_err - s1, 1);

    // Reset on beat 2 of an I read.
    bus.i_rw = 1; bus.i_addr = 32'h0000_0A00; bus.i_req = 1;
    cyc();
    bus.i_req = 0;
    wt = 0;
    while (!bus.sdr_req && wt < 10) begin
      cyc();
      wt++;
    end
    cyc();
    bus.sdr_cmd_ack = 1;
    cyc();
    bus.sdr_cmd_ack = 0;
    for (int b = 0; b < 2; b++) begin
      bus.sdr_rxd = 1;
      cyc();
      bus.sdr_rxd = 0;
    end
    check("reset pre grant", bus.i_grant, 1);
    s1 = m_err;
    bus.sdr_rxd = 1; Reset = 1;
    cyc();
    Reset = 0; bus.sdr_rxd = 0;
    check("reset mid-burst outputs", outs(), 64'd0);
    repeat (2) cyc();
    check("reset no bus_err", m_err - s1, 0);
    bus.d_rw = 1; bus.d_addr = 32'h0000_0C40; bus.d_req = 1;
    cyc();
    bus.d_req = 0;
    serve(2, 1'b1, 1'b0, r);
    check("post-reset winner", r.who, REQ_D);
    check("post-reset addr", r.addr, 32'h0000_0C40);
    check("post-reset wait", r.wait_c, 1);
    check("post-reset beats", r.own_beats, BL);
    check("post-reset grant cycles", r.gnt_cyc, 2 + BL + 2);

    check("never two grants", m_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
